// File: rtl/riscv_rf_pkg.sv
// Shared types and defaults for the register file with scoreboard.
package riscv_rf_pkg;

  localparam int unsigned RF_XLEN_DEFAULT  = 32;
  localparam int unsigned RF_NREGS_DEFAULT = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Pending-write scoreboard: per-register reservation bits, alloc handshake and busy flags.
module riscv_rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int unsigned NREGS    = RF_NREGS_DEFAULT,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          run_i,
  input  logic          alloc_valid_i,
  input  logic [AW-1:0] alloc_rd_i,
  output logic          alloc_ready_o,
  input  logic          we_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             we_run;
  logic             alloc_zero;

  always_comb begin
    we_run        = run_i && we_i;
    alloc_zero    = ZERO_REG && (alloc_rd_i == '0);
    alloc_ready_o = run_i && alloc_valid_i &&
                    (!pending_q[alloc_rd_i] || (we_run && (rd_addr_i == alloc_rd_i)));
    rs1_busy_o    = run_i && pending_q[rs1_addr_i] && !(we_run && (rd_addr_i == rs1_addr_i));
    rs2_busy_o    = run_i && pending_q[rs2_addr_i] && !(we_run && (rd_addr_i == rs2_addr_i));
  end

  // Set is applied after clear so a same-cycle re-reservation wins over the writeback.
  always_comb begin
    pending_d = pending_q;
    if (we_run) begin
      pending_d[rd_addr_i] = 1'b0;
    end
    if (alloc_ready_o && !alloc_zero) begin
      pending_d[alloc_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/riscv_regfile_sb.sv
// 2R1W integer register file with write bypass, pending-write scoreboard and post-reset clear sweep.
// Optional per-entry even parity with registered error flag: define RF_PARITY_EN.
module riscv_regfile_sb
  import riscv_rf_pkg::*;
#(
  parameter int unsigned  XLEN     = RF_XLEN_DEFAULT,
  parameter int unsigned  NREGS    = RF_NREGS_DEFAULT,
  parameter bit           ZERO_REG = 1'b1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            init_done,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alloc_valid,
  input  logic [AW-1:0]   alloc_rd,
  output logic            alloc_ready,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data
`ifdef RF_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            run;
  logic            byp1, byp2;
  logic            zero1, zero2;
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Sweep FSM: state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Sweep FSM: next state
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

  // Sweep FSM: outputs
  always_comb begin
    run       = (state_q == RUN);
    init_done = run;
  end

  // Single array write port shared by the clear sweep and writeback.
  always_comb begin
    arr_we    = resetn && (!run || (we && !is_zero(rd_addr)));
    arr_waddr = run ? rd_addr : clr_idx_q;
    arr_wdata = run ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs_q[arr_waddr] <= arr_wdata;
    end
  end

  always_comb begin
    zero1    = is_zero(rs1_addr);
    zero2    = is_zero(rs2_addr);
    byp1     = we && (rd_addr == rs1_addr);
    byp2     = we && (rd_addr == rs2_addr);
    rs1_data = '0;
    rs2_data = '0;
    if (run && !zero1) begin
      rs1_data = byp1 ? rd_data : regs_q[rs1_addr];
    end
    if (run && !zero2) begin
      rs2_data = byp2 ? rd_data : regs_q[rs2_addr];
    end
  end

  riscv_rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk           (clk),
    .resetn        (resetn),
    .run_i         (run),
    .alloc_valid_i (alloc_valid),
    .alloc_rd_i    (alloc_rd),
    .alloc_ready_o (alloc_ready),
    .we_i          (we),
    .rd_addr_i     (rd_addr),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy)
  );

`ifdef RF_PARITY_EN
  logic par_q [NREGS];
  logic perr1, perr2;
  logic perr_q;

  always_ff @(posedge clk) begin
    if (arr_we) begin
      par_q[arr_waddr] <= ^arr_wdata;
    end
  end

  always_comb begin
    perr1 = run && !zero1 && !byp1 && ((^regs_q[rs1_addr]) != par_q[rs1_addr]);
    perr2 = run && !zero2 && !byp2 && ((^regs_q[rs2_addr]) != par_q[rs2_addr]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr1 || perr2;
    end
  end

  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Self-checking bench for riscv_regfile_sb: clear sweep, bypass, scoreboard, reset abort, optional parity.
module tb_riscv_regfile_sb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        init_done;
  logic [4:0]  rs1_addr, rs2_addr, alloc_rd, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rs1_busy, rs2_busy, alloc_valid, alloc_ready, we;
`ifdef RF_PARITY_EN
  logic        parity_err;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  riscv_regfile_sb #(
    .XLEN     (32),
    .NREGS    (32),
    .ZERO_REG (1'b1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .init_done   (init_done),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .we          (we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
`ifdef RF_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  r1, r2;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] e1, e2;
    logic        eb1, eb2, ear;
  } vec_t;

  typedef struct {
    logic [31:0] d1, d2;
    logic        b1, b2, ar, id;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[16];

  function automatic vec_t mk(input logic w, input logic [4:0] rd, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic av, input logic [4:0] ard,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic eb1, input logic eb2, input logic ear);
    vec_t v;
    v.we = w;  v.rd = rd; v.wd = wd; v.r1 = r1; v.r2 = r2; v.av = av; v.ard = ard;
    v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ear = ear;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; leaves just after the next one.
  task automatic apply(input vec_t v, input string tag);
    exp_t e, g;
    we = v.we; rd_addr = v.rd; rd_data = v.wd;
    rs1_addr = v.r1; rs2_addr = v.r2;
    alloc_valid = v.av; alloc_rd = v.ard;
    e.d1 = v.e1; e.d2 = v.e2; e.b1 = v.eb1; e.b2 = v.eb2; e.ar = v.ear; e.id = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      g = sbq.pop_front();
      chk({tag, ".rs1_data"},    rs1_data,    g.d1);
      chk({tag, ".rs2_data"},    rs2_data,    g.d2);
      chk({tag, ".rs1_busy"},    rs1_busy,    g.b1);
      chk({tag, ".rs2_busy"},    rs2_busy,    g.b2);
      chk({tag, ".alloc_ready"}, alloc_ready, g.ar);
      chk({tag, ".init_done"},   init_done,   g.id);
    end
    @(posedge clk); #1;
  endtask

  // Starts just after the edge where resetn was released with junk traffic driven.
  task automatic sweep(input string tag);
    for (int k = 0; k <= 32; k++) begin
      if (k == 32) begin
        we = 1'b0; alloc_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("%s.init_done[%0d]", tag, k), init_done, (k == 32));
      if (k < 32) begin
        chk($sformatf("%s.rs1_data[%0d]", tag, k),    rs1_data,    32'd0);
        chk($sformatf("%s.rs2_busy[%0d]", tag, k),    rs2_busy,    32'd0);
        chk($sformatf("%s.alloc_ready[%0d]", tag, k), alloc_ready, 32'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 0,  32'h0,        5,  3, 0, 0, 32'h0,        32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 5,  32'hDEADBEEF, 5,  6, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0);
    tbl[2]  = mk(0, 0,  32'h0,        5,  5, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(0, 0,  32'h0,        0,  7, 1, 7, 32'h0,        32'h0,        0, 0, 1);
    tbl[4]  = mk(0, 0,  32'h0,        5,  7, 1, 7, 32'hDEADBEEF, 32'h0,        0, 1, 0);
    tbl[5]  = mk(1, 7,  32'h1111,     7,  7, 1, 7, 32'h1111,     32'h1111,     0, 0, 1);
    tbl[6]  = mk(0, 0,  32'h0,        7,  7, 0, 0, 32'h1111,     32'h1111,     1, 1, 0);
    tbl[7]  = mk(0, 0,  32'h0,        7,  5, 1, 7, 32'h1111,     32'hDEADBEEF, 1, 0, 0);
    tbl[8]  = mk(1, 0,  32'h1234,     0,  7, 1, 0, 32'h0,        32'h1111,     0, 1, 1);
    tbl[9]  = mk(0, 0,  32'h0,        0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 0);
    tbl[10] = mk(1, 7,  32'h2222,     7,  5, 0, 0, 32'h2222,     32'hDEADBEEF, 0, 0, 0);
    tbl[11] = mk(0, 0,  32'h0,        7,  7, 1, 9, 32'h2222,     32'h2222,     0, 0, 1);
    tbl[12] = mk(1, 31, 32'hFFFFFFFF, 31, 9, 1, 3, 32'hFFFFFFFF, 32'h0,        0, 1, 1);
    tbl[13] = mk(0, 0,  32'h0,        31, 3, 0, 0, 32'hFFFFFFFF, 32'h0,        0, 1, 0);
    tbl[14] = mk(1, 3,  32'h55,       3,  9, 0, 0, 32'h55,       32'h0,        0, 1, 0);
    tbl[15] = mk(0, 0,  32'h0,        3,  9, 1, 3, 32'h55,       32'h0,        0, 1, 1);

    // Power-on reset with traffic that the sweep must ignore.
    resetn = 1'b0;
    we = 1'b1; rd_addr = 5'd5; rd_data = 32'hFF;
    rs1_addr = 5'd5; rs2_addr = 5'd3;
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.init_done", init_done, 32'd0);
    chk("reset.rs1_data",  rs1_data,  32'd0);
    resetn = 1'b1;
    sweep("sweep0");

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Abort RUN with pending {3,9} and x3=0x55; traffic during the sweep is dropped.
    resetn = 1'b0;
    we = 1'b1; rd_addr = 5'd3; rd_data = 32'hAA;
    rs1_addr = 5'd3; rs2_addr = 5'd9;
    alloc_valid = 1'b1; alloc_rd = 5'd4;
    @(posedge clk); #1;
    chk("abort.init_done", init_done, 32'd0);
    chk("abort.rs2_busy",  rs2_busy,  32'd0);
    resetn = 1'b1;
    sweep("sweep1");
    apply(mk(0, 0, 32'h0, 3, 9,  0, 0, 32'h0, 32'h0, 0, 0, 0), "post0");
    apply(mk(0, 0, 32'h0, 5, 31, 1, 9, 32'h0, 32'h0, 0, 0, 1), "post1");

`ifdef RF_PARITY_EN
    apply(mk(1, 4, 32'h0000000F, 4, 0, 0, 0, 32'h0000000F, 32'h0, 0, 0, 0), "par_wr");
    chk("par.clean", parity_err, 32'd0);
    dut.regs_q[4] = dut.regs_q[4] ^ 32'h1;
    we = 1'b0; rs1_addr = 5'd4; rs2_addr = 5'd0; alloc_valid = 1'b0;
    @(posedge clk); #1;
    chk("par.flipped", parity_err, 32'd1);
    we = 1'b1; rd_addr = 5'd4; rd_data = 32'h10;
    @(posedge clk); #1;
    chk("par.bypassed", parity_err, 32'd0);
    we = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
- Parametrised successor to the core's 2R1W integer register file.
- Adds write-to-read bypass, a per-register pending-write scoreboard for the issue stage, and a sequential post-reset clear sweep, so there is no single-cycle reset fan-out to every flop.
- Sits between decode/issue (reads, alloc) and writeback (write port) of the 3-stage pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >=2.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- init_done  out  1  high once the clear sweep completes
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_data  out  XLEN  read port 2 data (combinational)
- rs1_busy  out  1  rs1 has an outstanding pending write
- rs2_busy  out  1  rs2 has an outstanding pending write
- alloc_valid  in  1  issue requests destination reservation
- alloc_rd  in  AW  destination being reserved
- alloc_ready  out  1  reservation accepted this cycle
- we  in  1  writeback valid
- rd_addr  in  AW  writeback address
- rd_data  in  XLEN  writeback data
- parity_err  out  1  present only with RF_PARITY_EN

Behaviour:
- Reset: clk and resetn are decided as one clock, synchronous active-low reset. A rising edge with resetn=0 sets state=CLEAR, clr_idx=0, pending=0 and init_done=0. The array itself is not reset directly.
- CLEAR state:
  - Each edge with resetn=1 writes 0 to regs[clr_idx] and increments clr_idx.
  - On the edge that clears index NREGS-1, state goes to RUN and init_done goes to 1.
  - init_done is therefore high exactly NREGS edges after resetn deasserts.
- During CLEAR:
  - rsX_data=0, rsX_busy=0, alloc_ready=0.
  - we and alloc_valid are ignored.
- Reads in RUN:
  - rsX_data = regs[rsX_addr].
  - Bypass: if we and rd_addr==rsX_addr (and not the zero register), rsX_data=rd_data in the same cycle.
  - Zero register (ZERO_REG=1) always reads 0.
- Busy: rsX_busy = pending[rsX_addr] and not (we and rd_addr==rsX_addr). Same-cycle writeback resolves the hazard.
- Write: on an edge with we in RUN, regs[rd_addr] <= rd_data and pending[rd_addr] <= 0. Writing a non-pending register is legal and just writes. Writes to register 0 are dropped.
- Alloc:
  - alloc_ready = init_done and alloc_valid and (not pending[alloc_rd], or same-cycle we with rd_addr==alloc_rd).
  - On accept, pending[alloc_rd] <= 1. Zero-register alloc is always accepted and sets nothing.
  - Alloc to a pending register is stalled (WAW).
- Simultaneous alloc and write to the same register: data is written and pending ends at 1 (new reservation wins).
- Reset mid-operation: aborts RUN or CLEAR, restarts the sweep from index 0 and clears all pending bits.
- Latency: write visible via bypass in the same cycle, from the array on the next cycle; pending set/clear visible the next cycle.

Optional Feature:
- Macro RF_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from written data; the clear sweep writes parity 0.
  - parity_err = (registered) OR over both read ports of the parity mismatch, for non-bypassed reads of non-zero registers in RUN. It is valid one cycle after the read.
  - parity_err resets to 0.
- Undefined: no parity storage and the parity_err port is absent.

Decomposition:
- Package riscv_rf_pkg: state encoding (CLEAR, RUN) and defaults for XLEN and NREGS.
- One sub-module, riscv_rf_scoreboard: pending vector, alloc_ready and busy logic.
- The top holds the array, bypass and the sweep FSM.

Test Plan:
- Reset held 3 cycles then released, NREGS=32 -> init_done low for 32 edges and high on the 32nd. All reads return 0, alloc_ready=0 throughout.
- RUN, we=1, rd=5, data=0xDEADBEEF, rs1=5 in the same cycle -> rs1_data=0xDEADBEEF via bypass; still 0xDEADBEEF the next cycle with we=0.
- alloc rd=7 accepted -> rs2=7 gives busy=1; second alloc rd=7 gives alloc_ready=0. Write rd=7 -> busy clears the same cycle, and a re-alloc that cycle is accepted with pending ending at 1.
- Write rd=0 data=0x1234 plus alloc rd=0 -> rs1=0 reads 0, busy 0, alloc_ready=1.
- Reset asserted mid-RUN with pending {3,9} and x3=0x55 -> after a full sweep x3 reads 0, no register busy.
- With RF_PARITY_EN, force-flip the stored bit 0 of x4 -> reading rs1=4 gives parity_err=1 the next cycle; a bypassed read of x4 gives no error.
